// File: rtl/tx_framer_if.sv
// Byte-side handshake and serial line bundle for tx_framer.
// master drives frame requests and payload bytes; slave is the framer itself.
interface tx_framer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_abort;
  logic       txdata;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_underrun;

  modport master (
    output tx_start, tx_data, tx_valid, tx_last, tx_abort,
    input  tx_ready, txdata, tx_busy, tx_done, tx_underrun
  );

  modport slave (
    input  tx_start, tx_data, tx_valid, tx_last, tx_abort,
    output tx_ready, txdata, tx_busy, tx_done, tx_underrun
  );
endinterface

// File: rtl/tx_framer.sv
// HDLC-style serial transmit framer: opening flags, zero-stuffed LSB-first payload, CRC-16-CCITT FCS, closing flag, abort.
// Define TX_FLAG_IDLE_EN to fill the idle line with 0x7E flags and start frames on flag boundaries.
module tx_framer #(
  parameter int unsigned OPEN_FLAGS = 1
) (
  input  logic       netclk,
  input  logic       reset,
  tx_framer_if.slave bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ONES_W = 3;

  localparam logic [BYTE_W-1:0] FLAG     = 8'h7E;
  localparam logic [CRC_W-1:0]  CRC_INIT = 16'hFFFF;
  localparam logic [CRC_W-1:0]  CRC_POLY = 16'h1020;
  localparam logic [ONES_W-1:0] STUFF_AT = 3'd5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_OPEN  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_FCS   = 3'd3;
  localparam logic [2:0] ST_CLOSE = 3'd4;
  localparam logic [2:0] ST_ABORT = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  flag_cnt_q, flag_cnt_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [CRC_W-1:0]  lfsr_q, lfsr_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              hold_last_q, hold_last_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              shift_last_q, shift_last_d;
  logic              fcs_pad_q, fcs_pad_d;
  logic              txdata_q, txdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;
  logic              load;
`ifdef TX_FLAG_IDLE_EN
  logic              start_pend_q, start_pend_d;
`endif

  logic abort_c;
  logic accept_c;
  logic fcs_bit_c;

  // One payload bit through the CCITT lfsr (x^16 + x^12 + x^5 + 1)
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic d);
    logic fb;
    fb = d ^ c[CRC_W-1];
    return {c[CRC_W-2:0], fb} ^ (CRC_POLY & {CRC_W{fb}});
  endfunction

  function automatic logic in_tx(input logic [2:0] s);
    return (s == ST_OPEN) || (s == ST_DATA);
  endfunction

  assign abort_c   = bus.tx_abort && ((state_q == ST_OPEN) || (state_q == ST_DATA) ||
                                      (state_q == ST_FCS)  || (state_q == ST_CLOSE));
  assign accept_c  = bus.tx_valid && ready_q && !abort_c;
  assign fcs_bit_c = ~lfsr_q[4'd15 - cnt_q];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flag_cnt_d   = flag_cnt_q;
    ones_d       = ones_q;
    lfsr_d       = lfsr_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    hold_last_d  = hold_last_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    fcs_pad_d    = fcs_pad_q;
    txdata_d     = 1'b1;
    done_d       = 1'b0;
    underrun_d   = 1'b0;
    load         = 1'b0;
`ifdef TX_FLAG_IDLE_EN
    start_pend_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef TX_FLAG_IDLE_EN
        // Idle flags keep running; a pending start is taken at the flag boundary
        txdata_d     = FLAG[cnt_q[2:0]];
        cnt_d        = {1'b0, cnt_q[2:0] + 3'd1};
        start_pend_d = start_pend_q | bus.tx_start;
        if (cnt_q[2:0] == 3'd7 && start_pend_d) begin
          state_d      = ST_OPEN;
          cnt_d        = '0;
          flag_cnt_d   = '0;
          lfsr_d       = CRC_INIT;
          start_pend_d = 1'b0;
        end
`else
        if (bus.tx_start) begin
          state_d    = ST_OPEN;
          cnt_d      = '0;
          flag_cnt_d = '0;
          lfsr_d     = CRC_INIT;
        end
`endif
      end

      ST_OPEN: begin
        txdata_d = FLAG[cnt_q[2:0]];
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q[2:0] == 3'd7) begin
          cnt_d = '0;
          if (flag_cnt_q == 4'(OPEN_FLAGS - 1)) begin
            if (hold_full_q) begin
              state_d = ST_DATA;
              ones_d  = '0;
              load    = 1'b1;
            end else begin
              state_d    = ST_ABORT;
              underrun_d = 1'b1;
            end
          end else begin
            flag_cnt_d = flag_cnt_q + 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (ones_q == STUFF_AT) begin
          txdata_d = 1'b0;
          ones_d   = '0;
        end else begin
          txdata_d = shift_q[0];
          ones_d   = shift_q[0] ? ones_q + 3'd1 : 3'd0;
          lfsr_d   = crc_step(lfsr_q, shift_q[0]);
          shift_d  = {1'b0, shift_q[BYTE_W-1:1]};
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q[2:0] == 3'd7) begin
            cnt_d = '0;
            if (shift_last_q) begin
              state_d   = ST_FCS;
              fcs_pad_d = 1'b0;
            end else if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d    = ST_ABORT;
              underrun_d = 1'b1;
            end
          end
        end
      end

      ST_FCS: begin
        // A stuff bit owed after the last FCS bit is sent before the closing flag
        if (ones_q == STUFF_AT) begin
          txdata_d = 1'b0;
          ones_d   = '0;
          if (fcs_pad_q) begin
            state_d   = ST_CLOSE;
            cnt_d     = '0;
            fcs_pad_d = 1'b0;
          end
        end else begin
          txdata_d = fcs_bit_c;
          ones_d   = fcs_bit_c ? ones_q + 3'd1 : 3'd0;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            cnt_d = '0;
            if (ones_d == STUFF_AT) fcs_pad_d = 1'b1;
            else                    state_d   = ST_CLOSE;
          end
        end
      end

      ST_CLOSE: begin
        txdata_d = FLAG[cnt_q[2:0]];
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q[2:0] == 3'd7) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_ABORT: begin
        txdata_d    = 1'b1;
        hold_full_d = 1'b0;
        cnt_d       = cnt_q + 4'd1;
        if (cnt_q[2:0] == 3'd7) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept_c) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
      hold_last_d = bus.tx_last;
    end

    if (load) begin
      shift_d      = hold_q;
      shift_last_d = hold_last_q;
      hold_full_d  = 1'b0;
    end

    // Abort overrides everything, including a byte offered in the same cycle
    if (abort_c) begin
      state_d     = ST_ABORT;
      cnt_d       = '0;
      hold_full_d = 1'b0;
      done_d      = 1'b0;
      underrun_d  = 1'b0;
    end
  end

  assign ready_d = in_tx(state_q) && in_tx(state_d) && !hold_full_d;
  assign busy_d  = (state_d != ST_IDLE);

  always_ff @(posedge netclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      flag_cnt_q   <= '0;
      ones_q       <= '0;
      lfsr_q       <= CRC_INIT;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      hold_last_q  <= 1'b0;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      fcs_pad_q    <= 1'b0;
      txdata_q     <= 1'b1;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef TX_FLAG_IDLE_EN
      start_pend_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flag_cnt_q   <= flag_cnt_d;
      ones_q       <= ones_d;
      lfsr_q       <= lfsr_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      hold_last_q  <= hold_last_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      fcs_pad_q    <= fcs_pad_d;
      txdata_q     <= txdata_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
`ifdef TX_FLAG_IDLE_EN
      start_pend_q <= start_pend_d;
`endif
    end
  end

  assign bus.txdata      = txdata_q;
  assign bus.tx_ready    = ready_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_underrun = underrun_q;

endmodule
